// File: rtl/apb_pkg.sv
// Shared state encoding, protection bits and width helpers for the multi-completer APB requester.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam logic [2:0] PROT_PRIV   = 3'b001;
  localparam logic [2:0] PROT_NONSEC = 3'b010;
  localparam logic [2:0] PROT_INSTR  = 3'b100;

  // Slave-index width; a single completer still needs one bit to carry the index.
  function automatic int idxWidth(input int numSlv);
    return (numSlv <= 1) ? 1 : $clog2(numSlv);
  endfunction

  function automatic int cntWidth(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_master_nslv_if.sv
// Command/response port plus shared APB segment, seen from the requester (master) or its environment (slave).
interface apb_master_nslv_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [ADDR_W-1:0]         cmd_addr;
  logic [DATA_W-1:0]         cmd_wdata;
  logic [STRB_W-1:0]         cmd_strb;
  logic [2:0]                cmd_prot;

  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_slverr;
  logic                      rsp_timeout;

  logic [NUM_SLV-1:0]        psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [STRB_W-1:0]         pstrb;
  logic [2:0]                pprot;
  logic [NUM_SLV*DATA_W-1:0] prdata;
  logic [NUM_SLV-1:0]        pready;
  logic [NUM_SLV-1:0]        pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational slave-index decode: picks the index field out of the address and flags out-of-range indices.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SLV_LSB = 12,
  localparam int IDX_W  = idxWidth(NUM_SLV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              hit
);

  logic unusedAddr;

  assign idx        = addr[SLV_LSB +: IDX_W];
  assign hit        = (int'(idx) < NUM_SLV);
  assign unusedAddr = ^addr;

endmodule

// File: rtl/apb_master_nslv.sv
// APB4 requester for NUM_SLV completers: one command in, one APB transfer out, one response back.
module apb_master_nslv
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SLV_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  apb_master_nslv_if.master  bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = idxWidth(NUM_SLV);
  localparam int CNT_W  = cntWidth(TIMEOUT);
  localparam int PAD_N  = 2 ** IDX_W;

  localparam logic [1:0] stIdle   = IDLE;
  localparam logic [1:0] stSetup  = SETUP;
  localparam logic [1:0] stAccess = ACCESS;
  localparam logic [1:0] stResp   = RESP;

  logic [1:0]        stateReg, stateNext;
  logic              readyReg;
  logic              writeReg;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] wdataReg;
  logic [STRB_W-1:0] strbReg;
  logic [2:0]        protReg;
  logic [IDX_W-1:0]  idxReg;
  logic [CNT_W-1:0]  waitReg;
  logic [DATA_W-1:0] rdataReg;
  logic              slverrReg;
  logic              timeoutReg;

  logic [IDX_W-1:0]   decIdx;
  logic               decHit;
  logic               accept;
  logic               busPhase;
  logic               selReady;
  logic               selErr;
  logic               waitExpired;
  logic [DATA_W-1:0]  selRdata;
  logic [NUM_SLV-1:0] pselVec;
  logic [DATA_W-1:0]  rdataPad [PAD_N];
  logic [PAD_N-1:0]   readyPad;
  logic [PAD_N-1:0]   errPad;

  apb_addr_decode #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV),
    .SLV_LSB (SLV_LSB)
  ) uDecode (
    .addr (bus.cmd_addr),
    .idx  (decIdx),
    .hit  (decHit)
  );

  // Completer returns are padded to a power of two so the index mux never goes out of range.
  genvar gi;
  generate
    for (gi = 0; gi < PAD_N; gi++) begin : gSlv
      if (gi < NUM_SLV) begin : gReal
        assign rdataPad[gi] = bus.prdata[gi*DATA_W +: DATA_W];
        assign readyPad[gi] = bus.pready[gi];
        assign errPad[gi]   = bus.pslverr[gi];
        assign pselVec[gi]  = busPhase && (idxReg == IDX_W'(gi));
      end else begin : gPad
        assign rdataPad[gi] = '0;
        assign readyPad[gi] = 1'b0;
        assign errPad[gi]   = 1'b0;
      end
    end
  endgenerate

  assign accept      = bus.cmd_valid && readyReg;
  assign busPhase    = (stateReg == stSetup) || (stateReg == stAccess);
  assign selReady    = readyPad[idxReg];
  assign selErr      = errPad[idxReg];
  assign selRdata    = rdataPad[idxReg];
  assign waitExpired = (TIMEOUT != 0) && (waitReg == CNT_W'(TIMEOUT - 1));

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      stIdle:   if (accept) stateNext = decHit ? stSetup : stResp;
      stSetup:  stateNext = stAccess;
      stAccess: if (selReady || waitExpired) stateNext = stResp;
      default:  stateNext = stIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg   <= stIdle;
      readyReg   <= 1'b0;
      writeReg   <= 1'b0;
      addrReg    <= '0;
      wdataReg   <= '0;
      strbReg    <= '0;
      protReg    <= '0;
      idxReg     <= '0;
      waitReg    <= '0;
      rdataReg   <= '0;
      slverrReg  <= 1'b0;
      timeoutReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      readyReg <= (stateNext == stIdle);
      if (accept) begin
        writeReg <= bus.cmd_write;
        addrReg  <= bus.cmd_addr;
        wdataReg <= bus.cmd_wdata;
        strbReg  <= bus.cmd_write ? bus.cmd_strb : '0;
        protReg  <= bus.cmd_prot;
        idxReg   <= decIdx;
        waitReg  <= '0;
        // A decode miss skips the bus entirely and answers from here.
        if (!decHit) begin
          rdataReg   <= '0;
          slverrReg  <= 1'b1;
          timeoutReg <= 1'b0;
        end
      end
      if (stateReg == stAccess) begin
        if (selReady) begin
          rdataReg   <= (!writeReg && !selErr) ? selRdata : '0;
          slverrReg  <= selErr;
          timeoutReg <= 1'b0;
        end else if (waitExpired) begin
          rdataReg   <= '0;
          slverrReg  <= 1'b1;
          timeoutReg <= 1'b1;
        end else begin
          waitReg <= waitReg + CNT_W'(1);
        end
      end
    end
  end

  assign bus.cmd_ready   = readyReg;
  assign bus.rsp_valid   = (stateReg == stResp);
  assign bus.rsp_rdata   = rdataReg;
  assign bus.rsp_slverr  = slverrReg;
  assign bus.rsp_timeout = timeoutReg;
  assign bus.psel        = pselVec;
  assign bus.penable     = (stateReg == stAccess);
  assign bus.pwrite      = writeReg;
  assign bus.paddr       = addrReg;
  assign bus.pwdata      = wdataReg;
  assign bus.pstrb       = strbReg;
  assign bus.pprot       = protReg;

endmodule

// File: tb/tb_apb_master_nslv.sv
// Drives one command stream into a 4-completer and a 3-completer requester and checks both against a transaction-level model.
module tb_apb_master_nslv;
  import apb_pkg::*;

  localparam int TMO = 16;

  logic clk;
  logic rst;

  logic        cmdValid;
  logic        cmdWrite;
  logic [31:0] cmdAddr;
  logic [31:0] cmdWdata;
  logic [3:0]  cmdStrb;
  logic [2:0]  cmdProt;

  int          waitCfg [4];
  bit          errCfg  [4];
  logic [31:0] rdCfg   [4];
  logic [3:0]  noiseRdy;
  logic [3:0]  noiseErr;
  logic [31:0] noiseData;
  int          accCnt  [2];

  logic [3:0]  obsPsel   [2];
  logic        obsPen    [2];
  logic        obsRspV   [2];
  logic        obsReady  [2];
  logic        obsSlverr [2];
  logic        obsTo     [2];
  logic        obsPwrite [2];
  logic [31:0] obsRdata  [2];
  logic [31:0] obsPaddr  [2];
  logic [31:0] obsPwdata [2];
  logic [3:0]  obsPstrb  [2];
  logic [2:0]  obsPprot  [2];

  int nTests;
  int nFail;

  apb_master_nslv_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) aIf ();
  apb_master_nslv_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3)) bIf ();

  apb_master_nslv #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_LSB(12), .TIMEOUT(TMO)
  ) dutA (
    .clk (clk),
    .rst (rst),
    .bus (aIf)
  );

  apb_master_nslv #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .SLV_LSB(12), .TIMEOUT(TMO)
  ) dutB (
    .clk (clk),
    .rst (rst),
    .bus (bIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign aIf.cmd_valid = cmdValid;
  assign aIf.cmd_write = cmdWrite;
  assign aIf.cmd_addr  = cmdAddr;
  assign aIf.cmd_wdata = cmdWdata;
  assign aIf.cmd_strb  = cmdStrb;
  assign aIf.cmd_prot  = cmdProt;
  assign bIf.cmd_valid = cmdValid;
  assign bIf.cmd_write = cmdWrite;
  assign bIf.cmd_addr  = cmdAddr;
  assign bIf.cmd_wdata = cmdWdata;
  assign bIf.cmd_strb  = cmdStrb;
  assign bIf.cmd_prot  = cmdProt;

  always_comb begin
    obsPsel[0]   = aIf.psel;
    obsPsel[1]   = {1'b0, bIf.psel};
    obsPen[0]    = aIf.penable;
    obsPen[1]    = bIf.penable;
    obsRspV[0]   = aIf.rsp_valid;
    obsRspV[1]   = bIf.rsp_valid;
    obsReady[0]  = aIf.cmd_ready;
    obsReady[1]  = bIf.cmd_ready;
    obsSlverr[0] = aIf.rsp_slverr;
    obsSlverr[1] = bIf.rsp_slverr;
    obsTo[0]     = aIf.rsp_timeout;
    obsTo[1]     = bIf.rsp_timeout;
    obsRdata[0]  = aIf.rsp_rdata;
    obsRdata[1]  = bIf.rsp_rdata;
    obsPwrite[0] = aIf.pwrite;
    obsPwrite[1] = bIf.pwrite;
    obsPaddr[0]  = aIf.paddr;
    obsPaddr[1]  = bIf.paddr;
    obsPwdata[0] = aIf.pwdata;
    obsPwdata[1] = bIf.pwdata;
    obsPstrb[0]  = aIf.pstrb;
    obsPstrb[1]  = bIf.pstrb;
    obsPprot[0]  = aIf.pprot;
    obsPprot[1]  = bIf.pprot;
  end

  // Completer models: the selected slave answers after waitCfg ACCESS cycles; every other line carries noise.
  always_ff @(posedge clk) begin
    accCnt[0] <= obsPen[0] ? accCnt[0] + 1 : 0;
    accCnt[1] <= obsPen[1] ? accCnt[1] + 1 : 0;
  end

  always_ff @(negedge clk) begin
    noiseRdy  <= 4'($urandom);
    noiseErr  <= 4'($urandom);
    noiseData <= $urandom;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (aIf.psel[k] && aIf.penable && (accCnt[0] >= waitCfg[k])) begin
        aIf.pready[k]             = 1'b1;
        aIf.pslverr[k]            = errCfg[k];
        aIf.prdata[k*32 +: 32]    = rdCfg[k];
      end else begin
        aIf.pready[k]             = noiseRdy[k] && !(aIf.psel[k] && aIf.penable);
        aIf.pslverr[k]            = noiseErr[k];
        aIf.prdata[k*32 +: 32]    = noiseData ^ 32'(k);
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (bIf.psel[k] && bIf.penable && (accCnt[1] >= waitCfg[k])) begin
        bIf.pready[k]             = 1'b1;
        bIf.pslverr[k]            = errCfg[k];
        bIf.prdata[k*32 +: 32]    = rdCfg[k];
      end else begin
        bIf.pready[k]             = noiseRdy[k] && !(bIf.psel[k] && bIf.penable);
        bIf.pslverr[k]            = noiseErr[k];
        bIf.prdata[k*32 +: 32]    = noiseData ^ 32'(k);
      end
    end
  end

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s[dut%0d]: got %0h want %0h", tag, d, obs, exp);
    end
  endtask

  // Model: one transaction is decided entirely by the target index, its wait count and its error flag.
  task automatic doCmd(input logic w, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [3:0] sb, input logic [2:0] pr);
    int          idx;
    int          waits;
    bit          tmo;
    bit          hit    [2];
    int          expPen [2];
    int          expSel [2];
    int          expLat [2];
    logic [31:0] expRd  [2];
    logic        expErr [2];
    logic        expTo  [2];
    int          lat    [2];
    int          penCnt [2];
    int          selCnt [2];
    bit          selBad [2];
    bit          rdyBad [2];
    idx   = int'(ad[13:12]);
    waits = waitCfg[idx];
    tmo   = (waits >= TMO);
    for (int d = 0; d < 2; d++) begin
      hit[d] = (idx < ((d == 0) ? 4 : 3));
      if (hit[d]) begin
        expPen[d] = tmo ? TMO : waits + 1;
        expSel[d] = expPen[d] + 1;
        expLat[d] = expSel[d] + 1;
        expErr[d] = tmo || errCfg[idx];
        expTo[d]  = tmo;
        expRd[d]  = (!w && !tmo && !errCfg[idx]) ? rdCfg[idx] : 32'h0;
      end else begin
        expPen[d] = 0;
        expSel[d] = 0;
        expLat[d] = 1;
        expErr[d] = 1'b1;
        expTo[d]  = 1'b0;
        expRd[d]  = 32'h0;
      end
      lat[d]    = -1;
      penCnt[d] = 0;
      selCnt[d] = 0;
      selBad[d] = 1'b0;
      rdyBad[d] = 1'b0;
    end

    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("ready_before", d, 32'(obsReady[d]), 32'h1);
    cmdWrite = w;
    cmdAddr  = ad;
    cmdWdata = wd;
    cmdStrb  = sb;
    cmdProt  = pr;
    cmdValid = 1'b1;
    @(posedge clk);
    #1 cmdValid = 1'b0;

    for (int c = 1; c <= 200 && (lat[0] < 0 || lat[1] < 0); c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (lat[d] < 0) begin
          if (c == 1) begin
            chk("paddr",   d, obsPaddr[d], ad);
            chk("pwrite",  d, 32'(obsPwrite[d]), 32'(w));
            chk("pwdata",  d, obsPwdata[d], wd);
            chk("pstrb",   d, 32'(obsPstrb[d]), w ? 32'(sb) : 32'h0);
            chk("pprot",   d, 32'(obsPprot[d]), 32'(pr));
            chk("psel_setup", d, 32'(obsPsel[d]), hit[d] ? 32'(4'b0001 << idx) : 32'h0);
            chk("penable_setup", d, 32'(obsPen[d]), 32'h0);
          end
          if (obsPen[d]) penCnt[d]++;
          if (obsPsel[d] != 4'h0) begin
            selCnt[d]++;
            if (obsPsel[d] != (4'b0001 << idx)) selBad[d] = 1'b1;
          end
          if (obsRspV[d]) begin
            lat[d] = c;
            chk("rsp_rdata",   d, obsRdata[d], expRd[d]);
            chk("rsp_slverr",  d, 32'(obsSlverr[d]), 32'(expErr[d]));
            chk("rsp_timeout", d, 32'(obsTo[d]), 32'(expTo[d]));
            chk("psel_resp",   d, 32'(obsPsel[d]), 32'h0);
          end else if (obsReady[d]) begin
            rdyBad[d] = 1'b1;
          end
        end
      end
    end

    for (int d = 0; d < 2; d++) begin
      chk("latency",     d, 32'(lat[d]), 32'(expLat[d]));
      chk("penable_cnt", d, 32'(penCnt[d]), 32'(expPen[d]));
      chk("psel_cnt",    d, 32'(selCnt[d]), 32'(expSel[d]));
      chk("psel_onehot", d, 32'(selBad[d]), 32'h0);
      chk("ready_busy",  d, 32'(rdyBad[d]), 32'h0);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rsp_pulse",   d, 32'(obsRspV[d]), 32'h0);
      chk("ready_after", d, 32'(obsReady[d]), 32'h1);
    end
    $display("[TB] txn w=%0d addr=%08h wait=%0d err=%0d | A lat=%0d rdata=%08h slverr=%0d to=%0d | B lat=%0d slverr=%0d",
             w, ad, waits, errCfg[idx], lat[0], obsRdata[0], obsSlverr[0], obsTo[0],
             lat[1], obsSlverr[1]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int opts [7];
    bit rspSeen;
    opts = '{0, 1, 2, 3, 15, 16, 1000};
    nTests   = 0;
    nFail    = 0;
    rst      = 1'b1;
    cmdValid = 1'b0;
    cmdWrite = 1'b0;
    cmdAddr  = '0;
    cmdWdata = '0;
    cmdStrb  = '0;
    cmdProt  = '0;
    for (int k = 0; k < 4; k++) begin
      waitCfg[k] = 0;
      errCfg[k]  = 1'b0;
      rdCfg[k]   = 32'h0;
    end

    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready",  d, 32'(obsReady[d]), 32'h0);
      chk("rst_psel",   d, 32'(obsPsel[d]), 32'h0);
      chk("rst_pen",    d, 32'(obsPen[d]), 32'h0);
      chk("rst_rspv",   d, 32'(obsRspV[d]), 32'h0);
      chk("rst_paddr",  d, obsPaddr[d], 32'h0);
      chk("rst_slverr", d, 32'(obsSlverr[d]), 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait write to slave 1.
    waitCfg[1] = 0;
    errCfg[1]  = 1'b0;
    doCmd(1'b1, 32'h0000_1004, 32'hA5A5_0001, 4'hF, PROT_PRIV);

    // Read from slave 3 with three wait states (decode miss on the 3-slave instance).
    waitCfg[3] = 3;
    errCfg[3]  = 1'b0;
    rdCfg[3]   = 32'h1234_5678;
    doCmd(1'b0, 32'h0000_3010, 32'hDEAD_BEEF, 4'hF, PROT_NONSEC);

    // Index 3 write: normal on the 4-slave instance, decode error on the 3-slave one.
    waitCfg[3] = 0;
    doCmd(1'b1, 32'h0000_3000, 32'h0BAD_F00D, 4'h3, 3'b000);

    // Slave 0 never ready: full timeout.
    waitCfg[0] = 1000;
    doCmd(1'b0, 32'h0000_0000, 32'h0, 4'hF, PROT_INSTR);

    // Slave 1 ready on the last cycle before the timeout would fire.
    waitCfg[1] = TMO - 1;
    rdCfg[1]   = 32'h5555_AAAA;
    doCmd(1'b0, 32'h0000_1FFC, 32'h0, 4'h0, 3'b000);

    // Slave 2 errors on a read while slave 0 lines keep toggling.
    waitCfg[2] = 0;
    errCfg[2]  = 1'b1;
    rdCfg[2]   = 32'hCAFE_F00D;
    doCmd(1'b0, 32'h0000_2008, 32'h0, 4'hF, 3'b000);

    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 4; k++) begin
        waitCfg[k] = opts[$urandom_range(0, 6)];
        errCfg[k]  = ($urandom_range(0, 3) == 0);
        rdCfg[k]   = $urandom;
      end
      doCmd(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), 3'($urandom));
    end

    // Reset while parked in ACCESS: everything drops at once and no response follows.
    waitCfg[0] = 1000;
    errCfg[0]  = 1'b0;
    @(negedge clk);
    cmdWrite = 1'b1;
    cmdAddr  = 32'h0000_0040;
    cmdWdata = 32'h1111_2222;
    cmdStrb  = 4'hF;
    cmdProt  = 3'b000;
    cmdValid = 1'b1;
    @(posedge clk);
    #1 cmdValid = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("mid_access_pen", d, 32'(obsPen[d]), 32'h1);
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("arst_psel",  d, 32'(obsPsel[d]), 32'h0);
      chk("arst_pen",   d, 32'(obsPen[d]), 32'h0);
      chk("arst_rspv",  d, 32'(obsRspV[d]), 32'h0);
      chk("arst_paddr", d, obsPaddr[d], 32'h0);
      chk("arst_ready", d, 32'(obsReady[d]), 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    rspSeen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (obsRspV[d]) rspSeen = 1'b1;
    end
    chk("no_rsp_after_rst", 0, 32'(rspSeen), 32'h0);

    waitCfg[0] = 0;
    rdCfg[0]   = 32'h0F0F_0F0F;
    doCmd(1'b0, 32'h0000_0010, 32'h0, 4'hF, 3'b000);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
